// File: rtl/serial_addr_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// Holds the FSM state encoding and the default operand width.
package serial_addr_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    // 2'd3 is unused and recovers to ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addr_ctrl_full_addr.sv
// 1-bit adder cells shared by the serial adder datapath.
// Ports: a, b, cin -> s (sum bit), cout (carry out).
module half_addr (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_addr (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_addr u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_addr u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_addr_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, one bit per clock, LSB first.
// Ports: clk, rst (async high), start, in1, in2, cin -> busy, done, sum, carry, ovf.
module serial_addr_ctrl
    import serial_addr_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] ps;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             s;
    logic             co;
    logic             last;

    assign last = (cnt == LAST);

    full_addr u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c),
        .s    (s),
        .cout (co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            ps    <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr <= in1;
                        b_sr <= in2;
                        c    <= cin;
                        ps   <= '0;
                        cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    c    <= co;
                    ps   <= {s, ps[WIDTH-1:1]};
                    if (last) begin
                        cnt   <= '0;
                        sum   <= {s, ps[WIDTH-1:1]};
                        carry <= co;
                        // c here is the carry into the MSB cell
                        ovf   <= c ^ co;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addr_ctrl.sv
// Directed self-checking bench for serial_addr_ctrl (WIDTH=8).
// Expected results queued at issue, popped and compared on done.
module tb_serial_addr_ctrl;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;

    int   ncmp = 0;
    int   nmis = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_addr_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry),
        .ovf   (ovf)
    );

    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic ci);
        exp_t e;
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        e.s = t[7:0];
        e.c = t[8];
        e.v = (a[7] == b[7]) && (t[7] != a[7]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, {24'd0, sum}, {24'd0, e.s});
            check({tag, "_carry"}, {31'd0, carry}, {31'd0, e.c});
            check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.v});
        end
    endtask

    // n0 = negedges already spent since the accept edge
    task automatic wait_done(input string tag, input int n0);
        int n;
        bit got;
        n = n0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1;
                break;
            end
        end
        check({tag, "_latency"}, n, 8);
        if (got) pop_cmp(tag);
        @(negedge clk);
        check({tag, "_done_width"}, {31'd0, done}, 0);
        check({tag, "_busy_end"}, {31'd0, busy}, 0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic ci);
        @(negedge clk);
        in1 = a;
        in2 = b;
        cin = ci;
        start = 1'b1;
        sb.push_back(model(a, b, ci));
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 1);
        wait_done(tag, 0);
    endtask

    initial begin
        int   cyc;
        int   last_done;
        int   ndone;
        int   nacc;
        logic prev_busy;
        logic [7:0] ra [3];
        logic [7:0] rb [3];
        logic       rc [3];

        rst = 1'b1;
        start = 1'b0;
        in1 = '0;
        in2 = '0;
        cin = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_sum", {24'd0, sum}, 0);
        check("rst_cc", {30'd0, carry, ovf}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("zero", 8'h00, 8'h00, 1'b0);
        run_op("ff_01", 8'hFF, 8'h01, 1'b0);
        run_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1);
        run_op("7f_01", 8'h7F, 8'h01, 1'b0);
        run_op("80_80", 8'h80, 8'h80, 1'b0);

        // second start during RUN must be dropped
        @(negedge clk);
        in1 = 8'h12;
        in2 = 8'h34;
        cin = 1'b0;
        start = 1'b1;
        sb.push_back(model(8'h12, 8'h34, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in1 = 8'hAA;
        in2 = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run_sum_hold", {24'd0, sum}, 32'h00);
        wait_done("ignore", 3);
        @(negedge clk);
        check("no_queue", {31'd0, busy}, 0);

        // reset mid-operation at cnt==3
        @(negedge clk);
        in1 = 8'h55;
        in2 = 8'h66;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_sum", {24'd0, sum}, 0);
        check("mid_rst_cc", {30'd0, carry, ovf}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_done", {31'd0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 8'h0F, 8'h01, 1'b0);

        // start held high: three back-to-back ops
        for (int i = 0; i < 3; i++) begin
            ra[i] = 8'($urandom);
            rb[i] = 8'($urandom);
            rc[i] = 1'($urandom);
        end
        @(negedge clk);
        in1 = ra[0];
        in2 = rb[0];
        cin = rc[0];
        start = 1'b1;
        sb.push_back(model(ra[0], rb[0], rc[0]));
        nacc = 0;
        ndone = 0;
        last_done = -1;
        prev_busy = 1'b0;
        for (cyc = 1; cyc <= 60 && ndone < 3; cyc++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                nacc++;
                if (nacc < 3) begin
                    in1 = ra[nacc];
                    in2 = rb[nacc];
                    cin = rc[nacc];
                    sb.push_back(model(ra[nacc], rb[nacc], rc[nacc]));
                end else begin
                    start = 1'b0;
                end
            end
            prev_busy = busy;
            if (done) begin
                pop_cmp("b2b");
                if (last_done >= 0) check("b2b_gap", cyc - last_done, 10);
                last_done = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b_count", ndone, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
